// File: rtl/history_buffer.sv
// Precise-exception history buffer: in-order retire; rollback of old register values from newest to oldest, then a one-cycle exception report.
// Strobes are registered one cycle after their cause; decode backpressure via alloc_ready_o/stall_decode_o. Optional HF_RETIRE_TRACE_EN adds a retire trace port.
module history_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int NUM_WB = 2
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  output logic [IDX_W-1:0]        alloc_tag_o,
  input  logic [XLEN-1:0]         alloc_pc_i,
  input  logic [REG_W-1:0]        alloc_dest_reg_i,
  input  logic [XLEN-1:0]         alloc_old_value_i,
  input  logic [NUM_WB-1:0]       wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0] wb_tag_i,
  input  logic [NUM_WB*XLEN-1:0]  wb_exc_i,
  input  logic [NUM_WB*XLEN-1:0]  wb_mtval_i,
  output logic                    stall_decode_o,
  output logic                    kill_instr_o,
  output logic                    rec_write_en_o,
  output logic [REG_W-1:0]        rec_dest_reg_o,
  output logic [XLEN-1:0]         rec_dest_reg_value_o,
  output logic                    exc_occured_o,
  output logic [XLEN-1:0]         exc_mepc_o,
  output logic [XLEN-1:0]         exc_mcause_o,
  output logic [XLEN-1:0]         exc_mtval_o,
  output logic [IDX_W:0]          count_o
`ifdef HF_RETIRE_TRACE_EN
  ,
  output logic                    retire_valid_o,
  output logic [XLEN-1:0]         retire_pc_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RECOVER, S_REPORT} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  old_value;
    logic [XLEN-1:0]  exc;
    logic [XLEN-1:0]  mtval;
  } entry_t;

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_head, r_tail, r_rp, w_rp_nxt;
  logic [IDX_W:0]   r_count;
  logic [DEPTH-1:0] r_valid, r_done;
  entry_t           r_ent [DEPTH];

  logic             r_kill, r_rec_we, r_exc;
  logic [REG_W-1:0] r_rec_dest;
  logic [XLEN-1:0]  r_rec_val, r_mepc, r_mcause, r_mtval;
  logic             w_kill_nxt, w_rec_we_nxt, w_exc_nxt;
  logic [REG_W-1:0] w_rec_dest_nxt;
  logic [XLEN-1:0]  w_rec_val_nxt, w_mepc_nxt, w_mcause_nxt, w_mtval_nxt;

  logic             w_alloc, w_head_cmpl, w_retire, w_fault;
  logic [DEPTH-1:0] w_wb_hit;
  logic [XLEN-1:0]  w_wb_exc   [DEPTH];
  logic [XLEN-1:0]  w_wb_mtval [DEPTH];

  assign alloc_ready_o  = (r_state == S_IDLE) && (r_count != FULL_CNT);
  assign stall_decode_o = (r_state != S_IDLE) || (r_count == FULL_CNT);
  assign alloc_tag_o    = r_tail;
  assign count_o        = r_count;

  assign kill_instr_o         = r_kill;
  assign rec_write_en_o       = r_rec_we;
  assign rec_dest_reg_o       = r_rec_dest;
  assign rec_dest_reg_value_o = r_rec_val;
  assign exc_occured_o        = r_exc;
  assign exc_mepc_o           = r_mepc;
  assign exc_mcause_o         = r_mcause;
  assign exc_mtval_o          = r_mtval;

  assign w_alloc     = alloc_valid_i && alloc_ready_o;
  assign w_head_cmpl = (r_state == S_IDLE) && r_valid[r_head] && r_done[r_head];
  assign w_retire    = w_head_cmpl && (r_ent[r_head].exc == '0);
  assign w_fault     = w_head_cmpl && (r_ent[r_head].exc != '0);

  // Channels scanned high to low so the lowest-index hit is the one that sticks.
  always_comb begin
    w_wb_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wb_exc[i]   = '0;
      w_wb_mtval[i] = '0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if ((r_state == S_IDLE) && wb_valid_i[k] && r_valid[i] && !r_done[i] &&
            (wb_tag_i[k*IDX_W +: IDX_W] == IDX_W'(i))) begin
          w_wb_hit[i]   = 1'b1;
          w_wb_exc[i]   = wb_exc_i[k*XLEN +: XLEN];
          w_wb_mtval[i] = wb_mtval_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rp_nxt       = r_rp;
    w_kill_nxt     = 1'b0;
    w_rec_we_nxt   = 1'b0;
    w_rec_dest_nxt = '0;
    w_rec_val_nxt  = '0;
    w_exc_nxt      = 1'b0;
    w_mepc_nxt     = '0;
    w_mcause_nxt   = '0;
    w_mtval_nxt    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fault) begin
          w_state_nxt = S_RECOVER;
          w_rp_nxt    = r_tail - IDX_ONE;
          w_kill_nxt  = 1'b1;
        end
      end
      S_RECOVER: begin
        w_rec_we_nxt   = 1'b1;
        w_rec_dest_nxt = r_ent[r_rp].dest;
        w_rec_val_nxt  = r_ent[r_rp].old_value;
        if (r_rp == r_head) w_state_nxt = S_REPORT;
        else                w_rp_nxt    = r_rp - IDX_ONE;
      end
      S_REPORT: begin
        w_exc_nxt    = 1'b1;
        w_mepc_nxt   = r_ent[r_head].pc;
        w_mcause_nxt = r_ent[r_head].exc;
        w_mtval_nxt  = r_ent[r_head].mtval;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state    <= S_IDLE;
      r_rp       <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_done     <= '0;
      r_kill     <= 1'b0;
      r_rec_we   <= 1'b0;
      r_rec_dest <= '0;
      r_rec_val  <= '0;
      r_exc      <= 1'b0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rp       <= w_rp_nxt;
      r_kill     <= w_kill_nxt;
      r_rec_we   <= w_rec_we_nxt;
      r_rec_dest <= w_rec_dest_nxt;
      r_rec_val  <= w_rec_val_nxt;
      r_exc      <= w_exc_nxt;
      r_mepc     <= w_mepc_nxt;
      r_mcause   <= w_mcause_nxt;
      r_mtval    <= w_mtval_nxt;
      if (r_state == S_REPORT) begin
        r_valid <= '0;
        r_done  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        // Bulk done update first; per-slot alloc/retire writes below take precedence.
        r_done <= r_done | w_wb_hit;
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_tail          <= r_tail + IDX_ONE;
        end
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_done[r_head]  <= 1'b0;
          r_head          <= r_head + IDX_ONE;
        end
        r_count <= r_count + {{IDX_W{1'b0}}, w_alloc} - {{IDX_W{1'b0}}, w_retire};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_ent[r_tail].pc        <= alloc_pc_i;
      r_ent[r_tail].dest      <= alloc_dest_reg_i;
      r_ent[r_tail].old_value <= alloc_old_value_i;
      r_ent[r_tail].exc       <= '0;
      r_ent[r_tail].mtval     <= '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wb_hit[i]) begin
        r_ent[i].exc   <= w_wb_exc[i];
        r_ent[i].mtval <= w_wb_mtval[i];
      end
    end
  end

`ifdef HF_RETIRE_TRACE_EN
  logic            r_ret_vld;
  logic [XLEN-1:0] r_ret_pc;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_ret_vld <= 1'b0;
      r_ret_pc  <= '0;
    end else begin
      r_ret_vld <= w_retire;
      r_ret_pc  <= w_retire ? r_ent[r_head].pc : '0;
    end
  end

  assign retire_valid_o = r_ret_vld;
  assign retire_pc_o    = r_ret_pc;
`endif

endmodule

// File: tb/tb_history_buffer.sv
// Directed bench for history_buffer: retire order, full buffer, exception rollback (plain and wrapped), writeback conflicts, reset mid-recovery.
module tb_history_buffer;
  localparam int DEPTH = 16, IDX_W = 4, XLEN = 32, REG_W = 5, NUM_WB = 2;

  logic                    clk = 1'b0;
  logic                    rsn_i;
  logic                    alloc_valid_i;
  logic                    alloc_ready_o;
  logic [IDX_W-1:0]        alloc_tag_o;
  logic [XLEN-1:0]         alloc_pc_i;
  logic [REG_W-1:0]        alloc_dest_reg_i;
  logic [XLEN-1:0]         alloc_old_value_i;
  logic [NUM_WB-1:0]       wb_valid_i;
  logic [NUM_WB*IDX_W-1:0] wb_tag_i;
  logic [NUM_WB*XLEN-1:0]  wb_exc_i;
  logic [NUM_WB*XLEN-1:0]  wb_mtval_i;
  logic                    stall_decode_o, kill_instr_o, rec_write_en_o, exc_occured_o;
  logic [REG_W-1:0]        rec_dest_reg_o;
  logic [XLEN-1:0]         rec_dest_reg_value_o, exc_mepc_o, exc_mcause_o, exc_mtval_o;
  logic [IDX_W:0]          count_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit seen_strobe = 1'b0;
  bit seen_exc    = 1'b0;

  always #5 clk = ~clk;

  history_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .REG_W(REG_W), .NUM_WB(NUM_WB)) dut (
    .clk_i(clk), .rsn_i(rsn_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .alloc_pc_i(alloc_pc_i), .alloc_dest_reg_i(alloc_dest_reg_i), .alloc_old_value_i(alloc_old_value_i),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_exc_i(wb_exc_i), .wb_mtval_i(wb_mtval_i),
    .stall_decode_o(stall_decode_o), .kill_instr_o(kill_instr_o),
    .rec_write_en_o(rec_write_en_o), .rec_dest_reg_o(rec_dest_reg_o),
    .rec_dest_reg_value_o(rec_dest_reg_value_o),
    .exc_occured_o(exc_occured_o), .exc_mepc_o(exc_mepc_o), .exc_mcause_o(exc_mcause_o),
    .exc_mtval_o(exc_mtval_o), .count_o(count_o)
  );

  always @(negedge clk) begin
    if (kill_instr_o || rec_write_en_o || exc_occured_o) seen_strobe = 1'b1;
    if (exc_occured_o) seen_exc = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_alloc(input logic [XLEN-1:0] pc, input logic [REG_W-1:0] rd, input logic [XLEN-1:0] old);
    alloc_valid_i = 1'b1; alloc_pc_i = pc; alloc_dest_reg_i = rd; alloc_old_value_i = old;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic do_wb(input int ch, input logic [IDX_W-1:0] tag, input logic [XLEN-1:0] exc,
                       input logic [XLEN-1:0] mtval);
    wb_valid_i = '0;
    wb_valid_i[ch] = 1'b1;
    wb_tag_i[ch*IDX_W +: IDX_W] = tag;
    wb_exc_i[ch*XLEN +: XLEN] = exc;
    wb_mtval_i[ch*XLEN +: XLEN] = mtval;
    tick();
    wb_valid_i = '0;
  endtask

  task automatic chk_rec(input string tag, input logic [REG_W-1:0] rd, input logic [XLEN-1:0] val);
    chk({tag, "_we"}, rec_write_en_o, 1);
    chk({tag, "_reg"}, rec_dest_reg_o, rd);
    chk({tag, "_val"}, rec_dest_reg_value_o, val);
  endtask

  task automatic do_reset();
    rsn_i = 1'b0;
    tick();
    rsn_i = 1'b1;
    tick();
  endtask

  initial begin
    rsn_i = 1'b0; alloc_valid_i = 1'b0; alloc_pc_i = '0; alloc_dest_reg_i = '0; alloc_old_value_i = '0;
    wb_valid_i = '0; wb_tag_i = '0; wb_exc_i = '0; wb_mtval_i = '0;
    tick(); tick();
    chk("rst_ready", alloc_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_tag", alloc_tag_o, 0);
    chk("rst_stall", stall_decode_o, 0);
    chk("rst_kill", kill_instr_o, 0);
    chk("rst_rec", rec_write_en_o, 0);
    chk("rst_exc", exc_occured_o, 0);
    rsn_i = 1'b1;
    tick();

    // In-order retire with out-of-order completion
    seen_strobe = 1'b0;
    do_alloc(32'h100, 5'd1, 32'h1);
    do_alloc(32'h104, 5'd2, 32'h2);
    chk("t1_tag2", alloc_tag_o, 2);
    do_alloc(32'h108, 5'd3, 32'h3);
    chk("t1_cnt3", count_o, 3);
    do_wb(0, 4'd2, 32'h0, 32'h0);
    do_wb(0, 4'd0, 32'h0, 32'h0);
    chk("t1_cnt_before", count_o, 3);
    do_wb(1, 4'd1, 32'h0, 32'h0);
    chk("t1_cnt_r0", count_o, 2);
    tick();
    chk("t1_cnt_r1", count_o, 1);
    tick();
    chk("t1_cnt_r2", count_o, 0);
    chk("t1_no_strobe", seen_strobe, 0);

    // Full buffer
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) do_alloc(32'h200 + 32'(4 * i), 5'd1, 32'h0);
    chk("t2_ready15", alloc_ready_o, 1);
    do_alloc(32'h23C, 5'd1, 32'h0);
    chk("t2_ready16", alloc_ready_o, 0);
    chk("t2_stall16", stall_decode_o, 1);
    chk("t2_cnt16", count_o, 16);
    do_alloc(32'hBAD, 5'd9, 32'hBAD);
    chk("t2_cnt17", count_o, 16);
    do_wb(0, 4'd0, 32'h0, 32'h0);
    chk("t2_ready_pre", alloc_ready_o, 0);
    tick();
    chk("t2_cnt_ret", count_o, 15);
    chk("t2_ready_ret", alloc_ready_o, 1);
    chk("t2_wrap_tag", alloc_tag_o, 0);

    // Exception at head
    do_reset();
    seen_strobe = 1'b0;
    do_alloc(32'h300, 5'd5, 32'hAA);
    do_alloc(32'h304, 5'd6, 32'hBB);
    do_alloc(32'h308, 5'd7, 32'hCC);
    do_wb(1, 4'd0, 32'd2, 32'hDEAD);
    chk("t3_no_kill_yet", kill_instr_o, 0);
    tick();
    chk("t3_kill", kill_instr_o, 1);
    chk("t3_stall", stall_decode_o, 1);
    chk("t3_ready", alloc_ready_o, 0);
    tick();
    chk("t3_kill_pulse", kill_instr_o, 0);
    chk_rec("t3_r0", 5'd7, 32'hCC);
    tick();
    chk_rec("t3_r1", 5'd6, 32'hBB);
    tick();
    chk_rec("t3_r2", 5'd5, 32'hAA);
    chk("t3_exc_early", exc_occured_o, 0);
    tick();
    chk("t3_rec_off", rec_write_en_o, 0);
    chk("t3_exc", exc_occured_o, 1);
    chk("t3_mepc", exc_mepc_o, 32'h300);
    chk("t3_mcause", exc_mcause_o, 2);
    chk("t3_mtval", exc_mtval_o, 32'hDEAD);
    chk("t3_cnt", count_o, 0);
    tick();
    chk("t3_exc_pulse", exc_occured_o, 0);

    // Wrapped recovery: move head to 14, then four entries at 14,15,0,1
    for (int i = 0; i < 14; i++) do_alloc(32'h400 + 32'(4 * i), 5'd1, 32'h0);
    for (int i = 0; i < 14; i++) do_wb(i % 2, 4'(i), 32'h0, 32'h0);
    for (int i = 0; i < 40 && count_o != 0; i++) tick();
    chk("t4_drain", count_o, 0);
    chk("t4_tag14", alloc_tag_o, 14);
    do_alloc(32'h500, 5'd20, 32'hA14);
    do_alloc(32'h504, 5'd21, 32'hA15);
    do_alloc(32'h508, 5'd22, 32'hA00);
    do_alloc(32'h50C, 5'd23, 32'hA01);
    chk("t4_cnt4", count_o, 4);
    do_wb(0, 4'd14, 32'd7, 32'h77);
    tick();
    chk("t4_kill", kill_instr_o, 1);
    tick();
    chk_rec("t4_idx1", 5'd23, 32'hA01);
    tick();
    chk_rec("t4_idx0", 5'd22, 32'hA00);
    tick();
    chk_rec("t4_idx15", 5'd21, 32'hA15);
    tick();
    chk_rec("t4_idx14", 5'd20, 32'hA14);
    tick();
    chk("t4_exc", exc_occured_o, 1);
    chk("t4_mepc", exc_mepc_o, 32'h500);
    chk("t4_mcause", exc_mcause_o, 7);
    chk("t4_mtval", exc_mtval_o, 32'h77);
    tick();

    // Same-tag conflict (ch0 wins), duplicate and unallocated completions ignored
    seen_strobe = 1'b0;
    do_wb(0, 4'd8, 32'd4, 32'h0);
    for (int i = 0; i < 4; i++) do_alloc(32'h600 + 32'(4 * i), 5'd2, 32'h0);
    wb_valid_i = 2'b11;
    wb_tag_i = {4'd3, 4'd3};
    wb_exc_i = {32'd5, 32'd0};
    wb_mtval_i = {32'h55, 32'h0};
    tick();
    wb_valid_i = '0;
    do_wb(0, 4'd1, 32'h0, 32'h0);
    do_wb(1, 4'd1, 32'd9, 32'h9);
    do_wb(0, 4'd2, 32'h0, 32'h0);
    chk("t5_cnt_hold", count_o, 4);
    do_wb(1, 4'd0, 32'h0, 32'h0);
    for (int i = 0; i < 20 && count_o != 0; i++) tick();
    tick(); tick();
    chk("t5_drain", count_o, 0);
    chk("t5_no_strobe", seen_strobe, 0);

    // Reset during the second restore cycle
    do_alloc(32'h700, 5'd3, 32'h30);
    do_alloc(32'h704, 5'd4, 32'h40);
    do_alloc(32'h708, 5'd5, 32'h50);
    do_wb(0, 4'd4, 32'd3, 32'h0);
    tick();
    chk("t6_kill", kill_instr_o, 1);
    tick();
    chk_rec("t6_r0", 5'd5, 32'h50);
    tick();
    chk_rec("t6_r1", 5'd4, 32'h40);
    rsn_i = 1'b0;
    #1;
    chk("t6_rec", rec_write_en_o, 0);
    chk("t6_reg", rec_dest_reg_o, 0);
    chk("t6_exc", exc_occured_o, 0);
    chk("t6_kill0", kill_instr_o, 0);
    chk("t6_ready", alloc_ready_o, 1);
    chk("t6_cnt", count_o, 0);
    chk("t6_stall", stall_decode_o, 0);
    chk("t6_tag", alloc_tag_o, 0);
    tick();
    seen_strobe = 1'b0;
    seen_exc = 1'b0;
    rsn_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_no_exc", seen_exc, 0);
    chk("t6_no_strobe", seen_strobe, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
